button_encoder: RTL and testbench

BUTTON_ENCODER -- requirements
Module: button_encoder

---
 rtl/button_encoder.sv | 138 +++++++++++++
 tb/tb_button_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_encoder.sv
// Four-button command encoder: synchronize, debounce, then gather presses inside a
// short chord window and emit a single-cycle command code (one-hot or confirm chord).
module button_encoder #(
    parameter int DEB_CYCLES   = 16,
    parameter int CHORD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] control,
    output logic [3:0] btn_level,
    output logic       reject,
    output logic [1:0] dbg_state
);

    localparam int DCW = $clog2(DEB_CYCLES) + 1;
    localparam int TW  = $clog2(CHORD_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        EMIT     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     level_q, prev_q;
    logic [DCW-1:0] cnt_q [4];
    logic [3:0]     mask_q, mask_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     control_q, control_d;
    logic           reject_q, reject_d;
    logic [3:0]     rise;
    logic           mask_ok;

    // Synchronizer and per-bit debounce; a level flips only after DEB_CYCLES
    // consecutive disagreeing samples, any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                    cnt_q[i]   <= '0;
                    level_q[i] <= ~level_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = level_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            timer_q   <= '0;
            control_q <= '0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            control_q <= control_d;
            reject_q  <= reject_d;
        end
    end

    // Timer holds on the exit cycle so it never counts past CHORD_CYCLES-1.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (rise != 4'd0) begin
                    mask_d  = rise;
                    timer_d = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                mask_d = mask_q | rise;
                if (mask_d == 4'hF || timer_q == TW'(CHORD_CYCLES - 1)) begin
                    state_d = EMIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            EMIT: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (level_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered alongside the EMIT state so they pulse for exactly that cycle.
    always_comb begin
        mask_ok   = (mask_d == 4'hF) ||
                    ((mask_d != 4'd0) && ((mask_d & (mask_d - 4'd1)) == 4'd0));
        control_d = 4'd0;
        reject_d  = 1'b0;
        if (state_d == EMIT) begin
            if (mask_ok) begin
                control_d = mask_d;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    assign control   = control_q;
    assign btn_level = level_q;
    assign reject    = reject_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_button_encoder.sv
// Bench for button_encoder: cycle-stamped reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and pulse counts.
module tb_button_encoder;

    localparam int DEB   = 4;
    localparam int CHORD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'd0;
    logic [3:0] control;
    logic [3:0] btn_level;
    logic       reject;
    logic [1:0] dbg_state;

    button_encoder #(.DEB_CYCLES(DEB), .CHORD_CYCLES(CHORD)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .control   (control),
        .btn_level (btn_level),
        .reject    (reject),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: raw -> 2-cycle delay -> run-length debounce -> chord window
    // measured in absolute cycle numbers from the edge that first saw a press.
    logic [3:0] m_s1 = 0, m_s2 = 0, m_lvl = 0, m_prev = 0, m_acc = 0, m_ctrl = 0;
    logic [3:0] m_rise, m_new;
    logic       m_rej = 0;
    int         m_run [4] = '{0, 0, 0, 0};
    int         m_start = 0;
    bit         m_live = 0;
    bit         m_win = 0, m_emitting = 0, m_hold = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0; m_acc = 0;
            m_ctrl = 0; m_rej = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_win = 0; m_emitting = 0; m_hold = 0;
            m_live = 1;
        end else begin
            m_rise = m_lvl & ~m_prev;
            m_ctrl = 0;
            m_rej  = 0;
            if (m_emitting) begin
                m_emitting = 0;
                m_hold     = 1;
            end else if (m_hold) begin
                if (m_lvl == 0) m_hold = 0;
            end else if (m_win) begin
                m_acc = m_acc | m_rise;
                if (m_acc == 4'hF || cyc - m_start == CHORD) begin
                    if (m_acc == 4'hF || $countones(m_acc) == 1) m_ctrl = m_acc;
                    else m_rej = 1;
                    m_win = 0;
                    m_emitting = 1;
                end
            end else if (m_rise != 0) begin
                m_acc   = m_rise;
                m_start = cyc;
                m_win   = 1;
            end
            m_new = m_lvl;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_new[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_prev = m_lvl;
            m_lvl  = m_new;
            m_s2   = m_s1;
            m_s1   = btn_raw;
        end
    end

    // Per-cycle compare plus event stamps used by the directed checks.
    int         pulse_cnt = 0, pulse_cyc = 0, rej_cnt = 0, rej_cyc = 0;
    int         rise_cyc = 0, rise0_cyc = 0;
    logic [3:0] last_code = 0, mon_prev = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("control", control, m_ctrl);
            chk("btn_level", btn_level, m_lvl);
            chk("reject", {3'b000, reject}, {3'b000, m_rej});
            if ((btn_level & ~mon_prev) != 0) rise_cyc = cyc;
            if (btn_level[0] && !mon_prev[0]) rise0_cyc = cyc;
            mon_prev = btn_level;
            if (control != 0) begin
                pulse_cnt++;
                pulse_cyc = cyc;
                last_code = control;
            end
            if (reject) begin
                rej_cnt++;
                rej_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int d, r, pb, rb;

    initial begin
        rst = 1'b1;
        btn_raw = 4'd0;
        steps(3);
        chk("reset_control", control, 4'd0);
        chk("reset_level", btn_level, 4'd0);
        chk("reset_reject", {3'b000, reject}, 4'd0);
        rst = 1'b0;
        steps(2);

        // Single button0 press held.
        pb = pulse_cnt; rb = rej_cnt;
        btn_raw = 4'b1000; d = cyc;
        steps(40);
        chk_int("single_pulses", pulse_cnt - pb, 1);
        chk("single_code", last_code, 4'b1000);
        chk_int("single_debounce_lat", rise_cyc - d, 6);
        chk_int("single_emit_lat", pulse_cyc - rise_cyc, 9);
        chk_int("single_rejects", rej_cnt - rb, 0);
        btn_raw = 4'b0000;
        steps(20);

        // Staggered full chord: bits 3..0 on cycles 0,2,3,5.
        pb = pulse_cnt; rb = rej_cnt;
        btn_raw = 4'b1000; d = cyc;
        steps(2);
        btn_raw = 4'b1100;
        steps(1);
        btn_raw = 4'b1110;
        steps(2);
        btn_raw = 4'b1111;
        steps(30);
        chk_int("chord_pulses", pulse_cnt - pb, 1);
        chk("chord_code", last_code, 4'b1111);
        chk_int("chord_bit0_rise", rise0_cyc - d, 11);
        chk_int("chord_lat", pulse_cyc - rise0_cyc, 1);
        chk_int("chord_rejects", rej_cnt - rb, 0);
        btn_raw = 4'b0000;
        steps(20);

        // Partial chord is discarded.
        pb = pulse_cnt; rb = rej_cnt;
        btn_raw = 4'b1100;
        steps(30);
        chk_int("partial_pulses", pulse_cnt - pb, 0);
        chk_int("partial_rejects", rej_cnt - rb, 1);
        chk_int("partial_rej_lat", rej_cyc - rise_cyc, 9);
        btn_raw = 4'b0000;
        steps(20);

        // Bouncing button1 settles, then held.
        pb = pulse_cnt; rb = rej_cnt;
        for (int k = 0; k < 5; k++) begin
            btn_raw = 4'b0100;
            steps(2);
            btn_raw = 4'b0000;
            steps(2);
        end
        chk_int("bounce_no_pulse", pulse_cnt - pb, 0);
        btn_raw = 4'b0100; d = cyc;
        steps(30);
        chk_int("bounce_debounce_lat", rise_cyc - d, 6);
        chk_int("bounce_pulses", pulse_cnt - pb, 1);
        chk("bounce_code", last_code, 4'b0100);
        btn_raw = 4'b0000;
        steps(20);

        // Press during WAIT_REL is ignored; a fresh press after release is seen.
        pb = pulse_cnt;
        btn_raw = 4'b1000;
        steps(20);
        btn_raw = 4'b1100;
        steps(25);
        chk_int("waitrel_pulses", pulse_cnt - pb, 1);
        btn_raw = 4'b0000;
        steps(15);
        btn_raw = 4'b0100;
        steps(25);
        chk_int("waitrel_new_pulses", pulse_cnt - pb, 2);
        chk("waitrel_new_code", last_code, 4'b0100);
        btn_raw = 4'b0000;
        steps(15);

        // Reset mid-COLLECT with button2 held.
        pb = pulse_cnt;
        btn_raw = 4'b0010;
        steps(10);
        rst = 1'b1; r = cyc;
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_control", control, 4'd0);
        steps(28);
        chk_int("rst_pulses", pulse_cnt - pb, 1);
        chk("rst_code", last_code, 4'b0010);
        chk_int("rst_relevel_lat", rise_cyc - r, 7);
        chk_int("rst_emit_lat", pulse_cyc - r, 16);
        btn_raw = 4'b0000;
        steps(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
